// File: rtl/piece_bag_generator_pkg.sv
//============================================================================
// Module : polytris_pkg
// Brief  : Piece ids, 4x4 shape masks, LFSR taps and generator FSM states.
// Rev    : 1.0
//============================================================================
`default_nettype none

package polytris_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_id_t;

    // Bit i*4+j of each mask is row i, column j of the 4x4 preview grid.
    localparam logic [15:0] SHAPE_MASK [0:6] = '{
        16'h00F0, 16'h0660, 16'h0270, 16'h0360,
        16'h0630, 16'h0470, 16'h0170
    };

    // x^16 + x^14 + x^13 + x^11, left-shifting Fibonacci form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [6:0] BAG_FULL = 7'h7F;

    typedef enum logic [2:0] {
        ST_PRIME0 = 3'd0,
        ST_PRIME1 = 3'd1,
        ST_IDLE   = 3'd2,
        ST_DRAW   = 3'd3,
        ST_COMMIT = 3'd4
    } gen_state_t;

endpackage

`default_nettype wire

// File: rtl/piece_bag_generator_lfsr.sv
//============================================================================
// Module : piece_lfsr
// Brief  : Free-running 16-bit Fibonacci LFSR, loaded with SEED on reset.
// Rev    : 1.0
//============================================================================
`default_nettype none

module piece_lfsr
    import polytris_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[14:0], ^(r_state & LFSR_TAPS)};
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/piece_bag_generator.sv
//============================================================================
// Module : piece_bag_generator
// Brief  : 7-bag tetromino randomiser holding a current and a next piece.
// Rev    : 1.0
//============================================================================
`default_nettype none

module piece_bag_generator
    import polytris_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  generator_flag,
    input  logic [15:0] random_noise,
    output logic [15:0] game_piece,
    output logic [15:0] cur_piece,
    output logic [2:0]  cur_id,
    output logic [2:0]  next_id,
    output logic        piece_valid
);

    gen_state_t  r_state;
    gen_state_t  w_state_nxt;
    logic        r_req;
    logic        r_edge;
    logic        r_pending;
    logic        r_primed;
    logic        r_tgt_cur;
    logic [6:0]  r_bag;
    logic [2:0]  r_cand;
    piece_id_t   r_cur_id;
    piece_id_t   r_next_id;
    logic [15:0] r_cur_mask;
    logic [15:0] r_next_mask;

    logic [15:0] w_lfsr;
    logic        w_req;
    logic [2:0]  w_mix;
    logic [2:0]  w_entry_cand;
    logic [2:0]  w_cand_inc;
    logic [6:0]  w_bag_set;
    logic        w_advance;

    piece_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RESET   (RESET),
        .o_state (w_lfsr)
    );

    assign w_req        = |generator_flag;
    assign w_mix        = w_lfsr[2:0] ^ random_noise[2:0];
    assign w_entry_cand = (w_mix == 3'd7) ? 3'd0 : w_mix;
    assign w_cand_inc   = (r_cand == 3'd6) ? 3'd0 : r_cand + 3'd1;
    assign w_bag_set    = r_bag | (7'b1 << r_cand);
    assign w_advance    = (r_state == ST_IDLE) && (r_edge || r_pending);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PRIME0: w_state_nxt = ST_DRAW;
            ST_PRIME1: w_state_nxt = ST_DRAW;
            ST_IDLE:   if (w_advance) w_state_nxt = ST_DRAW;
            ST_DRAW:   if (!r_bag[r_cand]) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = r_tgt_cur ? ST_PRIME1 : ST_IDLE;
            default:   w_state_nxt = ST_PRIME0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_PRIME0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_req       <= 1'b0;
            r_edge      <= 1'b0;
            r_pending   <= 1'b0;
            r_primed    <= 1'b0;
            r_tgt_cur   <= 1'b0;
            r_bag       <= 7'h00;
            r_cand      <= 3'd0;
            r_cur_id    <= PIECE_I;
            r_next_id   <= PIECE_I;
            r_cur_mask  <= 16'h0000;
            r_next_mask <= 16'h0000;
        end else begin
            r_req  <= w_req;
            r_edge <= w_req & ~r_req;

            if (r_state == ST_IDLE) begin
                r_primed <= 1'b1;
            end

            // IDLE always consumes pending; an edge landing while pending is set is dropped.
            if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end else if (r_edge && r_primed) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_PRIME0: begin
                    r_cand    <= w_entry_cand;
                    r_tgt_cur <= 1'b1;
                end
                ST_PRIME1: begin
                    r_cand    <= w_entry_cand;
                    r_tgt_cur <= 1'b0;
                end
                ST_IDLE: begin
                    if (w_advance) begin
                        r_cand     <= w_entry_cand;
                        r_tgt_cur  <= 1'b0;
                        r_cur_id   <= r_next_id;
                        r_cur_mask <= r_next_mask;
                    end
                end
                ST_DRAW: begin
                    if (r_bag[r_cand]) begin
                        r_cand <= w_cand_inc;
                    end
                end
                ST_COMMIT: begin
                    if (r_tgt_cur) begin
                        r_cur_id   <= piece_id_t'(r_cand);
                        r_cur_mask <= SHAPE_MASK[r_cand];
                    end else begin
                        r_next_id   <= piece_id_t'(r_cand);
                        r_next_mask <= SHAPE_MASK[r_cand];
                    end
                    r_bag <= (w_bag_set == BAG_FULL) ? 7'h00 : w_bag_set;
                end
                default: ;
            endcase
        end
    end

    assign game_piece  = r_next_mask;
    assign cur_piece   = r_cur_mask;
    assign cur_id      = r_cur_id;
    assign next_id     = r_next_id;
    assign piece_valid = (r_state == ST_IDLE);

endmodule

`default_nettype wire
